// File: rtl/sram_req_arbiter.sv
// Two-requester arbiter for one SRAM-like bus port, with an in-order tag FIFO that routes responses back.
// Build option: define SRAM_ARB_RR_EN for round-robin priority (default is fixed data-over-inst).
module sram_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          count;
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [OUTSTANDING-1:0] tags;
    logic                   grant, sel_data, want_data;
    logic                   handshake, pop, spurious, head_tag;
    logic                   fifo_full, fifo_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count == CW'(OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head_tag   = tags[rd_ptr];

`ifdef SRAM_ARB_RR_EN
    // last_grant: 0 = inst, 1 = data; the other side wins a tie
    logic last_grant;

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b0;
        else if (handshake)
            last_grant <= sel_data;
    end

    assign want_data = data_req && (!inst_req || !last_grant);
`else
    assign want_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           if (grant && !mem_addr_ok) state_nxt = sel_data ? LOCK_D : LOCK_I;
            LOCK_I, LOCK_D: if (mem_addr_ok) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant    = 1'b0;
        sel_data = 1'b0;
        case (state)
            IDLE: begin
                grant    = !fifo_full && (inst_req || data_req);
                sel_data = want_data;
            end
            LOCK_I: grant = 1'b1;
            LOCK_D: begin
                grant    = 1'b1;
                sel_data = 1'b1;
            end
            default: ;
        endcase
        if (reset)
            grant = 1'b0;
    end

    assign mem_req   = grant;
    assign mem_wr    = sel_data ? data_wr    : inst_wr;
    assign mem_size  = sel_data ? data_size  : inst_size;
    assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = sel_data ? data_addr  : inst_addr;
    assign mem_wdata = sel_data ? data_wdata : inst_wdata;

    assign handshake    = grant && mem_addr_ok;
    assign inst_addr_ok = handshake && !sel_data;
    assign data_addr_ok = handshake && sel_data;

    assign pop          = mem_data_ok && !fifo_empty && !reset;
    assign spurious     = mem_data_ok && fifo_empty && !reset;
    assign inst_data_ok = pop && !head_tag;
    assign data_data_ok = pop && head_tag;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            tags    <= '0;
            arb_err <= 1'b0;
        end else begin
            if (handshake) begin
                tags[wr_ptr] <= sel_data;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (handshake && !pop)
                count <= count + 1'b1;
            else if (pop && !handshake)
                count <= count - 1'b1;
            if (spurious)
                arb_err <= 1'b1;
        end
    end
endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Shares one SRAM-like bus port (req/addr_ok/data_ok protocol) between the fetch-side instruction requester and the memory-stage data requester. Selects one request per address phase, holds that grant until the bus accepts the address, and records the issuer of every accepted request in an in-order tag FIFO so that each `data_ok` and its `rdata` are routed back to the correct requester. Sits between the pipeline's IF/EX-MEM access logic and the top-level bus or bridge.

## Interface
- `OUTSTANDING`, default 2: maximum number of accepted-but-unanswered requests (tag FIFO depth). Legal values are 1–8.
- `clk`  in  1  clock. Synchronous and active-high; all state updates occur on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_req`, `inst_wr`, `inst_size`, `inst_wstrb`, `inst_addr`, `inst_wdata`  in  1/1/2/4/32/32  instruction-side request. The requester holds these stable until `inst_addr_ok`.
- `inst_addr_ok`  out  1  instruction address phase accepted.
- `inst_data_ok`  out  1  instruction response valid.
- `inst_rdata`  out  32  instruction response data.
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`  in  1/1/2/4/32/32  data-side request, with the same hold rule.
- `data_addr_ok`  out  1  data address phase accepted.
- `data_data_ok`  out  1  data response valid (for both loads and stores).
- `data_rdata`  out  32  data response data.
- `mem_req`, `mem_wr`, `mem_size`, `mem_wstrb`, `mem_addr`, `mem_wdata`  out  1/1/2/4/32/32  request to the shared bus.
- `mem_addr_ok`  in  1  bus accepted the address.
- `mem_data_ok`  in  1  bus response valid. Responses return in acceptance order.
- `mem_rdata`  in  32  bus response data.
- `arb_err`  out  1  sticky flag: a `mem_data_ok` arrived while the tag FIFO was empty.

## Operation
- Grant FSM has three states: IDLE, LOCK_I, LOCK_D.
- **IDLE:**
  - If `count < OUTSTANDING` and any request is present, choose a winner by the priority rule below.
  - Drive `mem_*` from the winner combinationally, with `mem_req` = 1.
  - If `mem_addr_ok` is also high in that cycle, the handshake completes in that cycle and the FSM stays in IDLE.
  - Otherwise the FSM moves to LOCK_I or LOCK_D to match the winner.
- **LOCK_x:**
  - `mem_*` is driven from the locked source only. The other source is ignored even if it has higher priority.
  - On `mem_addr_ok`, the handshake completes and the FSM returns to IDLE.
  - The next grant is made no earlier than the following cycle.
- **Priority (default):** data requests always win over instruction requests.
- **Handshake completion:**
  - `inst_addr_ok` or `data_addr_ok` = `mem_addr_ok` AND (granted source is that side), in the same cycle.
  - The source ID is pushed into the tag FIFO: 0 = inst, 1 = data.
- **Full FIFO:** when `count == OUTSTANDING`, `mem_req` = 0 in IDLE, even if a pop happens in the same cycle. In LOCK_x the FIFO cannot be full, because the grant was only made when `count < OUTSTANDING`.
- **Responses:**
  - On `mem_data_ok` with the FIFO non-empty, pop the head tag.
  - Assert `inst_data_ok` or `data_data_ok` for that tag in the same cycle.
  - `inst_rdata` = `data_rdata` = `mem_rdata`, always (broadcast).
- **Response with empty FIFO:** the response is dropped, no `*_data_ok` is asserted, and `arb_err` is set to 1. `arb_err` clears only on reset.
- **FIFO counting:**
  - A push and a pop in the same cycle leave `count` unchanged.
  - Read and write pointers wrap modulo `OUTSTANDING`.
  - `count` is `$clog2(OUTSTANDING+1)` bits wide.
- **Request withdrawn while locked:** a requester that drops `req` while in LOCK_x violates the protocol. The FSM stays locked until `mem_addr_ok`; no recovery is required.

## Timing
- **Reset values:**
  - FSM = IDLE, `count` = 0, pointers = 0, `arb_err` = 0.
  - While `reset` is high: `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` are forced to 0.
- **Address-phase latency:** 0 cycles from `*_req` to `mem_req` in IDLE. The addr_ok passthrough is combinational.
- **Response-routing latency:** 0 cycles from `mem_data_ok` to `*_data_ok`.
- **Throughput:**
  - Up to one accepted request per cycle when the bus returns `addr_ok` in the same cycle as `req`.
  - After a LOCK state, the next grant is made in the following cycle.
- **Reset with requests outstanding:** the FIFO is cleared. Late bus responses then hit the empty FIFO and set `arb_err`. The bench must reset the bus model together with this block.

## Configuration
- `SRAM_ARB_RR_EN`:
  - **Defined:** round-robin priority. A 1-bit `last_grant` register (reset value = inst) is updated on each completed address handshake. In IDLE, when both sides request, the side not equal to `last_grant` wins.
  - **Undefined:** fixed data-over-instruction priority, and no `last_grant` register is built.

## Test plan
- **Single inst read, same-cycle accept:**
  - Stimulus: `inst_req`=1, `inst_addr`=0x1C000000, `mem_addr_ok`=1.
  - Required in that cycle: `mem_addr`=0x1C000000, `inst_addr_ok`=1.
  - Next: `mem_data_ok` with `mem_rdata`=0xDEADBEEF gives `inst_data_ok`=1, `inst_rdata`=0xDEADBEEF, `count` back to 0.
- **Both request, fixed priority:**
  - Stimulus: `inst_req` and `data_req` both high, `data_addr`=0x100, `mem_addr_ok` held low for 3 cycles.
  - Required: `mem_addr`=0x100 stable all 4 cycles; FSM in LOCK_D; `data_addr_ok` only in cycle 4; inst granted in cycle 5.
  - With `SRAM_ARB_RR_EN` and `last_grant`=data, the same stimulus must grant inst first.
- **Full FIFO, `OUTSTANDING`=2:**
  - Stimulus: two accepted requests (inst then data) with no response, then a third `inst_req`.
  - Required: `mem_req`=0.
  - After the first `mem_data_ok`: `inst_data_ok`=1 and `mem_req` rises in the next cycle. The second response must route to `data_data_ok`.
- **Simultaneous push and pop:**
  - Stimulus: `count`=1, with a new handshake and a `mem_data_ok` in the same cycle.
  - Required: `count` stays 1, and tag order is preserved across pointer wrap-around (10 alternating requests).
- **Spurious response:**
  - Stimulus: `mem_data_ok`=1 with `count`=0.
  - Required: no `*_data_ok`, `arb_err`=1 held until `reset`.
- **Reset mid-lock:**
  - Stimulus: assert `reset` while in LOCK_I with `count`=1.
  - Required next cycle: FSM=IDLE, `count`=0, all handshake outputs 0.
